// File: rtl/sa_cache_ctrl_if.sv
// ----------------------------------------------------------------------------
// sa_cache_ctrl_if
// Bundles the CPU load/store handshake and the line-wide memory port of the
// set-associative cache controller. Signal prefixes are named from the
// controller's point of view: i_* flow into the cache, o_* flow out of it.
//
// CPU side:
//   i_req_valid / o_req_ready   request handshake
//   i_req_we, i_addr, i_wdata   request payload (word-aligned byte address)
//   o_resp_valid, o_rdata       one-cycle response pulse and its data word
// Memory side:
//   o_mem_req_valid / i_mem_req_ready   line request handshake
//   o_mem_we, o_mem_addr, o_mem_wline   writeback / refill request payload
//   i_mem_resp_valid, i_mem_rline       refill line return
//
// Modports:
//   slave  - the cache controller
//   master - the environment (CPU + memory) driving the controller
// ----------------------------------------------------------------------------
interface sa_cache_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LINE_BITS     = 512
);
    logic                     i_req_valid;
    logic                     o_req_ready;
    logic                     i_req_we;
    logic [ADDRESS_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0]    i_wdata;
    logic                     o_resp_valid;
    logic [DATA_WIDTH-1:0]    o_rdata;

    logic                     o_mem_req_valid;
    logic                     i_mem_req_ready;
    logic                     o_mem_we;
    logic [ADDRESS_WIDTH-1:0] o_mem_addr;
    logic [LINE_BITS-1:0]     o_mem_wline;
    logic                     i_mem_resp_valid;
    logic [LINE_BITS-1:0]     i_mem_rline;

    modport slave (
        input  i_req_valid, i_req_we, i_addr, i_wdata,
        input  i_mem_req_ready, i_mem_resp_valid, i_mem_rline,
        output o_req_ready, o_resp_valid, o_rdata,
        output o_mem_req_valid, o_mem_we, o_mem_addr, o_mem_wline
    );

    modport master (
        output i_req_valid, i_req_we, i_addr, i_wdata,
        output i_mem_req_ready, i_mem_resp_valid, i_mem_rline,
        input  o_req_ready, o_resp_valid, o_rdata,
        input  o_mem_req_valid, o_mem_we, o_mem_addr, o_mem_wline
    );
endinterface

// File: rtl/sa_cache_ctrl.sv
// ----------------------------------------------------------------------------
// sa_cache_ctrl
// N-way set-associative, write-back, write-allocate cache controller between
// a single CPU load/store port and a line-wide memory port. Hits complete in
// the LOOKUP cycle with a true-LRU age update; misses choose a victim (lowest
// invalid way, else the oldest way), write it back when dirty, refill the line
// and replay the lookup, which then hits.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - sa_cache_ctrl_if.slave (CPU request/response + memory line port)
// ----------------------------------------------------------------------------
module sa_cache_ctrl #(
    parameter int SETS          = 256,
    parameter int WAYS          = 4,
    parameter int LINE_BYTES    = 64,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    sa_cache_ctrl_if.slave bus
);
    localparam int OFFSET_BITS   = $clog2(LINE_BYTES);
    localparam int INDEX_BITS    = $clog2(SETS);
    localparam int TAG_BITS      = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int AGE_BITS      = $clog2(WAYS);
    localparam int LINE_BITS     = 8 * LINE_BYTES;
    localparam int WORD_SEL_BITS = OFFSET_BITS - 2;
    localparam int BIT_SEL_BITS  = $clog2(LINE_BITS);

    localparam logic [AGE_BITS-1:0] AGE_MAX = AGE_BITS'(WAYS - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LOOKUP      = 3'd1;
    localparam logic [2:0] S_WRITEBACK   = 3'd2;
    localparam logic [2:0] S_REFILL_REQ  = 3'd3;
    localparam logic [2:0] S_REFILL_WAIT = 3'd4;
    localparam logic [2:0] S_RESPOND     = 3'd5;

    // Controller state and the captured request
    logic [2:0]               r_state;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [AGE_BITS-1:0]      r_victim;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_mem_we;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [LINE_BITS-1:0]     r_mem_wline;

    // Per-way metadata (reset) and tag/data storage (not reset)
    logic                     r_valid [SETS][WAYS];
    logic                     r_dirty [SETS][WAYS];
    logic [AGE_BITS-1:0]      r_age   [SETS][WAYS];
    logic [TAG_BITS-1:0]      r_tag   [SETS][WAYS];
    logic [LINE_BITS-1:0]     r_data  [SETS][WAYS];

    logic [INDEX_BITS-1:0]    w_idx;
    logic [TAG_BITS-1:0]      w_tag;
    logic [WORD_SEL_BITS-1:0] w_word;
    logic [BIT_SEL_BITS-1:0]  w_bit_lo;
    logic                     w_hit;
    logic [AGE_BITS-1:0]      w_hit_way;
    logic [AGE_BITS-1:0]      w_hit_age;
    logic                     w_has_inv;
    logic [AGE_BITS-1:0]      w_inv_way;
    logic [AGE_BITS-1:0]      w_lru_way;
    logic [AGE_BITS-1:0]      w_victim;
    logic                     w_victim_dirty;
    logic                     w_refill_done;
    logic                     w_write_hit;
    logic                     w_unused_addr_bits;

    assign w_idx    = r_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_tag    = r_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
    assign w_word   = r_addr[2 +: WORD_SEL_BITS];
    assign w_bit_lo = {w_word, 5'b00000};

    // Byte-lane bits of the address never select anything.
    assign w_unused_addr_bits = ^r_addr[1:0];

    // Tag compare across the indexed set; at most one way can match.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AGE_BITS'(w);
            end
        end
    end

    assign w_hit_age = r_age[w_idx][w_hit_way];

    // Victim choice: scanning downward leaves the lowest invalid way selected;
    // with a full set the oldest way (age == WAYS-1) is evicted.
    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        w_lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = AGE_BITS'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (r_age[w_idx][w] == AGE_MAX) begin
                w_lru_way = AGE_BITS'(w);
            end
        end
    end

    assign w_victim       = w_has_inv ? w_inv_way : w_lru_way;
    assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
    assign w_refill_done  = (r_state == S_REFILL_WAIT) && bus.i_mem_resp_valid;
    assign w_write_hit    = (r_state == S_LOOKUP) && w_hit && r_we;

    // Main FSM, request capture, memory request registers and metadata.
    // The memory request payload is registered when the request is first
    // raised so it cannot move while the memory side is stalling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_victim    <= '0;
            r_rdata     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wline <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_age[s][w]   <= AGE_BITS'(w);
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_req_valid) begin
                        r_we    <= bus.i_req_we;
                        r_addr  <= bus.i_addr;
                        r_wdata <= bus.i_wdata;
                        r_state <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_we) begin
                            r_rdata                   <= r_wdata;
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                        end else begin
                            r_rdata <= r_data[w_idx][w_hit_way][w_bit_lo +: DATA_WIDTH];
                        end
                        // True-LRU: younger ways age by one, the hit way becomes newest.
                        for (int w = 0; w < WAYS; w++) begin
                            if (AGE_BITS'(w) == w_hit_way) begin
                                r_age[w_idx][w] <= '0;
                            end else if (r_age[w_idx][w] < w_hit_age) begin
                                r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                            end
                        end
                        r_state <= S_RESPOND;
                    end else begin
                        r_victim <= w_victim;
                        if (w_victim_dirty) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx, {OFFSET_BITS{1'b0}}};
                            r_mem_wline <= r_data[w_idx][w_victim];
                            r_state     <= S_WRITEBACK;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= {w_tag, w_idx, {OFFSET_BITS{1'b0}}};
                            r_state     <= S_REFILL_REQ;
                        end
                    end
                end

                S_WRITEBACK: begin
                    if (bus.i_mem_req_ready) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_tag, w_idx, {OFFSET_BITS{1'b0}}};
                        r_state    <= S_REFILL_REQ;
                    end
                end

                S_REFILL_REQ: begin
                    if (bus.i_mem_req_ready) begin
                        r_state <= S_REFILL_WAIT;
                    end
                end

                S_REFILL_WAIT: begin
                    if (bus.i_mem_resp_valid) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_state                  <= S_LOOKUP;
                    end
                end

                S_RESPOND: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and line storage carry no reset; they only matter once the
    // matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_write_hit) begin
            r_data[w_idx][w_hit_way][w_bit_lo +: DATA_WIDTH] <= r_wdata;
        end
        if (w_refill_done) begin
            r_data[w_idx][r_victim] <= bus.i_mem_rline;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
    end

    assign bus.o_req_ready     = (r_state == S_IDLE);
    assign bus.o_resp_valid    = (r_state == S_RESPOND);
    assign bus.o_rdata         = r_rdata;
    assign bus.o_mem_req_valid = (r_state == S_WRITEBACK) || (r_state == S_REFILL_REQ);
    assign bus.o_mem_we        = r_mem_we;
    assign bus.o_mem_addr      = r_mem_addr;
    assign bus.o_mem_wline     = r_mem_wline;
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sa_cache_ctrl
// Directed bench for sa_cache_ctrl with default parameters (256 sets, 4 ways,
// 64-byte lines). A small line store stands in for memory: lines never
// written back return a fixed pattern in which word 0 of line 0x1040 is
// 0xDEADBEEF.
// ----------------------------------------------------------------------------
module tb_sa_cache_ctrl;
    localparam int LB = 512;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sa_cache_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .LINE_BITS(LB)) bus ();

    sa_cache_ctrl #(
        .SETS(256), .WAYS(4), .LINE_BYTES(64), .DATA_WIDTH(32), .ADDRESS_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the most recent CPU access
    logic [31:0]   acc_rdata;
    int            acc_lat;
    int            acc_wb_cnt;
    logic [31:0]   acc_wb_addr;
    logic [LB-1:0] acc_wb_line;
    int            acc_rf_cnt;
    logic [31:0]   acc_rf_addr;
    logic          acc_timeout;
    logic          acc_unstable;
    logic          acc_ready;

    logic [LB-1:0] mem_store [logic [31:0]];

    function automatic logic [31:0] pat_word(input logic [31:0] a, input int w);
        return 32'hDEADBEEF ^ a ^ 32'h0000_1040 ^ (32'(w) << 16);
    endfunction

    function automatic logic [LB-1:0] mem_line(input logic [31:0] a);
        logic [LB-1:0] l;
        if (mem_store.exists(a)) begin
            l = mem_store[a];
        end else begin
            for (int w = 0; w < 16; w++) l[32*w +: 32] = pat_word(a, w);
        end
        return l;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.i_mem_req_ready = 1'b0; bus.i_mem_resp_valid = 1'b0; bus.i_mem_rline = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One CPU access with an inline zero-wait memory; the first memory
    // request can be stalled for 'stall' cycles with a spurious refill pulse.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int stall);
        int            stall_left;
        logic          pend;
        logic [31:0]   pend_addr;
        logic          stalled_prev;
        logic [31:0]   prev_addr;
        logic          prev_we;
        logic          done;
        stall_left = stall; pend = 1'b0; pend_addr = '0; stalled_prev = 1'b0;
        prev_addr = '0; prev_we = 1'b0; done = 1'b0;
        acc_rdata = '0; acc_lat = 0; acc_wb_cnt = 0; acc_wb_addr = '0; acc_wb_line = '0;
        acc_rf_cnt = 0; acc_rf_addr = '0; acc_timeout = 1'b0; acc_unstable = 1'b0;
        @(negedge clk);
        acc_ready = bus.o_req_ready;
        bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_addr = addr; bus.i_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_addr = 32'hFFFF_FFFC; bus.i_wdata = 32'hA5A5_A5A5;
        for (int k = 1; k <= 300 && !done; k++) begin
            bus.i_mem_req_ready = 1'b0;
            bus.i_mem_resp_valid = 1'b0;
            if (bus.o_resp_valid) begin
                acc_rdata = bus.o_rdata;
                acc_lat = k;
                done = 1'b1;
            end else if (pend) begin
                bus.i_mem_resp_valid = 1'b1;
                bus.i_mem_rline = mem_line(pend_addr);
                pend = 1'b0;
            end else if (bus.o_mem_req_valid) begin
                if (stalled_prev && (bus.o_mem_addr !== prev_addr || bus.o_mem_we !== prev_we))
                    acc_unstable = 1'b1;
                prev_addr = bus.o_mem_addr;
                prev_we = bus.o_mem_we;
                if (stall_left > 0) begin
                    stall_left--;
                    stalled_prev = 1'b1;
                    bus.i_mem_resp_valid = 1'b1;
                    bus.i_mem_rline = '1;
                end else begin
                    stalled_prev = 1'b0;
                    bus.i_mem_req_ready = 1'b1;
                    if (bus.o_mem_we) begin
                        acc_wb_cnt++;
                        acc_wb_addr = bus.o_mem_addr;
                        acc_wb_line = bus.o_mem_wline;
                        mem_store[bus.o_mem_addr] = bus.o_mem_wline;
                    end else begin
                        acc_rf_cnt++;
                        acc_rf_addr = bus.o_mem_addr;
                        pend = 1'b1;
                        pend_addr = bus.o_mem_addr;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        bus.i_mem_req_ready = 1'b0;
        bus.i_mem_resp_valid = 1'b0;
        if (!done) acc_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.i_mem_req_ready = 1'b0; bus.i_mem_resp_valid = 1'b0; bus.i_mem_rline = '0;
        #1;
        total++; if (bus.o_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b want 1", bus.o_req_ready); end
        total++; if (bus.o_resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_valid: got %b want 0", bus.o_resp_valid); end
        total++; if (bus.o_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata: got %h want 0", bus.o_rdata); end
        total++; if (bus.o_mem_req_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_valid: got %b want 0", bus.o_mem_req_valid); end
        total++; if (bus.o_mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_we: got %b want 0", bus.o_mem_we); end
        total++; if (bus.o_mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem_addr: got %h want 0", bus.o_mem_addr); end
        total++; if (bus.o_mem_wline !== '0) begin bad++; $display("[TB] FAIL rst_mem_wline: got nonzero want 0"); end
        do_reset();
    endtask

    task automatic test_clean_miss();
        do_access(1'b0, 32'h0000_1040, 32'h0, 0);
        total++; if (acc_timeout !== 1'b0) begin bad++; $display("[TB] FAIL miss_timeout: got %b want 0", acc_timeout); end
        total++; if (acc_ready !== 1'b1) begin bad++; $display("[TB] FAIL miss_ready: got %b want 1", acc_ready); end
        total++; if (acc_rf_cnt !== 1) begin bad++; $display("[TB] FAIL miss_refills: got %0d want 1", acc_rf_cnt); end
        total++; if (acc_wb_cnt !== 0) begin bad++; $display("[TB] FAIL miss_writebacks: got %0d want 0", acc_wb_cnt); end
        total++; if (acc_rf_addr !== 32'h0000_1040) begin bad++; $display("[TB] FAIL miss_rf_addr: got %h want 00001040", acc_rf_addr); end
        total++; if (acc_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL miss_rdata: got %h want deadbeef", acc_rdata); end
        total++; if (acc_lat !== 5) begin bad++; $display("[TB] FAIL miss_latency: got %0d want 5", acc_lat); end
    endtask

    task automatic test_write_hit();
        do_access(1'b1, 32'h0000_1044, 32'h1234_5678, 0);
        total++; if (acc_rf_cnt + acc_wb_cnt !== 0) begin bad++; $display("[TB] FAIL whit_memreq: got %0d want 0", acc_rf_cnt + acc_wb_cnt); end
        total++; if (acc_lat !== 2) begin bad++; $display("[TB] FAIL whit_latency: got %0d want 2", acc_lat); end
        total++; if (acc_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL whit_echo: got %h want 12345678", acc_rdata); end
        do_access(1'b0, 32'h0000_1044, 32'h0, 0);
        total++; if (acc_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL rhit_rdata: got %h want 12345678", acc_rdata); end
        total++; if (acc_lat !== 2) begin bad++; $display("[TB] FAIL rhit_latency: got %0d want 2", acc_lat); end
        do_access(1'b0, 32'h0000_1040, 32'h0, 0);
        total++; if (acc_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL rhit_word0: got %h want deadbeef", acc_rdata); end
    endtask

    task automatic test_lru_victim();
        logic [31:0] fill [4];
        fill[0] = 32'h1040; fill[1] = 32'h5040; fill[2] = 32'h9040; fill[3] = 32'hD040;
        do_reset();
        foreach (fill[i]) begin
            do_access(1'b0, fill[i], 32'h0, 0);
            total++; if (acc_rdata !== pat_word(fill[i], 0)) begin bad++; $display("[TB] FAIL fill_rdata_%0d: got %h want %h", i, acc_rdata, pat_word(fill[i], 0)); end
        end
        do_access(1'b0, 32'h1040, 32'h0, 0);
        total++; if (acc_lat !== 2) begin bad++; $display("[TB] FAIL lru_rehit_latency: got %0d want 2", acc_lat); end
        do_access(1'b0, 32'h0001_1048, 32'h0, 0);
        total++; if (acc_wb_cnt !== 0) begin bad++; $display("[TB] FAIL lru_clean_wb: got %0d want 0", acc_wb_cnt); end
        total++; if (acc_rf_addr !== 32'h0001_1040) begin bad++; $display("[TB] FAIL lru_rf_addr: got %h want 00011040", acc_rf_addr); end
        total++; if (acc_rdata !== pat_word(32'h0001_1040, 2)) begin bad++; $display("[TB] FAIL lru_rdata: got %h want %h", acc_rdata, pat_word(32'h0001_1040, 2)); end
        do_access(1'b0, 32'h9040, 32'h0, 0);
        total++; if (acc_rf_cnt !== 0) begin bad++; $display("[TB] FAIL lru_9040_kept: got %0d refills want 0", acc_rf_cnt); end
        do_access(1'b0, 32'h5040, 32'h0, 0);
        total++; if (acc_rf_cnt !== 1) begin bad++; $display("[TB] FAIL lru_5040_evicted: got %0d refills want 1", acc_rf_cnt); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] seq [3];
        seq[0] = 32'h9040; seq[1] = 32'hD040; seq[2] = 32'h1040;
        do_reset();
        do_access(1'b0, 32'h1040, 32'h0, 0);
        do_access(1'b0, 32'h5040, 32'h0, 0);
        do_access(1'b0, 32'h9040, 32'h0, 0);
        do_access(1'b0, 32'hD040, 32'h0, 0);
        do_access(1'b1, 32'h5040, 32'hCAFE_F00D, 0);
        total++; if (acc_lat !== 2) begin bad++; $display("[TB] FAIL dirty_write_latency: got %0d want 2", acc_lat); end
        foreach (seq[i]) begin
            do_access(1'b0, seq[i], 32'h0, 0);
            total++; if (acc_rf_cnt !== 0) begin bad++; $display("[TB] FAIL dirty_touch_%0d: got %0d refills want 0", i, acc_rf_cnt); end
        end
        do_access(1'b0, 32'h0001_5040, 32'h0, 0);
        total++; if (acc_wb_cnt !== 1) begin bad++; $display("[TB] FAIL dirty_wb_cnt: got %0d want 1", acc_wb_cnt); end
        total++; if (acc_wb_addr !== 32'h0000_5040) begin bad++; $display("[TB] FAIL dirty_wb_addr: got %h want 00005040", acc_wb_addr); end
        total++; if (acc_wb_line[31:0] !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL dirty_wb_word0: got %h want cafef00d", acc_wb_line[31:0]); end
        total++; if (acc_wb_line[63:32] !== pat_word(32'h5040, 1)) begin bad++; $display("[TB] FAIL dirty_wb_word1: got %h want %h", acc_wb_line[63:32], pat_word(32'h5040, 1)); end
        total++; if (acc_rf_addr !== 32'h0001_5040) begin bad++; $display("[TB] FAIL dirty_rf_addr: got %h want 00015040", acc_rf_addr); end
        total++; if (acc_lat !== 6) begin bad++; $display("[TB] FAIL dirty_latency: got %0d want 6", acc_lat); end
        do_access(1'b0, 32'h5040, 32'h0, 0);
        total++; if (acc_wb_cnt !== 0) begin bad++; $display("[TB] FAIL dirty_reload_wb: got %0d want 0", acc_wb_cnt); end
        total++; if (acc_rdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL dirty_reload_rdata: got %h want cafef00d", acc_rdata); end
    endtask

    task automatic test_backpressure();
        do_reset();
        do_access(1'b0, 32'h0000_2084, 32'h0, 10);
        total++; if (acc_timeout !== 1'b0) begin bad++; $display("[TB] FAIL bp_timeout: got %b want 0", acc_timeout); end
        total++; if (acc_unstable !== 1'b0) begin bad++; $display("[TB] FAIL bp_stable: got %b want 0", acc_unstable); end
        total++; if (acc_rf_addr !== 32'h0000_2080) begin bad++; $display("[TB] FAIL bp_rf_addr: got %h want 00002080", acc_rf_addr); end
        total++; if (acc_rdata !== pat_word(32'h2080, 1)) begin bad++; $display("[TB] FAIL bp_rdata: got %h want %h", acc_rdata, pat_word(32'h2080, 1)); end
        total++; if (acc_lat !== 15) begin bad++; $display("[TB] FAIL bp_latency: got %0d want 15", acc_lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        a[0] = 32'h2080; a[1] = 32'h2088; a[2] = 32'h20BC;
        foreach (a[i]) begin
            do_access(1'b0, a[i], 32'h0, 0);
            total++; if (acc_lat !== 2 || acc_rdata !== pat_word(32'h2080, (a[i][5:0] >> 2))) begin
                bad++; $display("[TB] FAIL b2b_%0d: got lat %0d data %h want lat 2 data %h", i, acc_lat, acc_rdata, pat_word(32'h2080, (a[i][5:0] >> 2)));
            end
        end
    endtask

    task automatic test_reset_mid_miss();
        logic granted;
        granted = 1'b0;
        do_reset();
        @(negedge clk);
        bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_addr = 32'h0000_3000;
        @(posedge clk);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        for (int k = 0; k < 20 && !granted; k++) begin
            if (bus.o_mem_req_valid) begin
                bus.i_mem_req_ready = 1'b1;
                granted = 1'b1;
            end
            @(negedge clk);
        end
        bus.i_mem_req_ready = 1'b0;
        total++; if (granted !== 1'b1) begin bad++; $display("[TB] FAIL rmid_request: got %b want 1", granted); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.o_req_ready !== 1'b1 || bus.o_mem_req_valid !== 1'b0 || bus.o_resp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rmid_ctrl: got ready %b memv %b resp %b want 1 0 0", bus.o_req_ready, bus.o_mem_req_valid, bus.o_resp_valid);
        end
        total++; if (bus.o_mem_addr !== 32'h0 || bus.o_mem_we !== 1'b0 || bus.o_rdata !== 32'h0) begin
            bad++; $display("[TB] FAIL rmid_data: got addr %h we %b rdata %h want 0 0 0", bus.o_mem_addr, bus.o_mem_we, bus.o_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        do_access(1'b0, 32'h0000_3000, 32'h0, 0);
        total++; if (acc_rf_cnt !== 1) begin bad++; $display("[TB] FAIL rmid_remiss: got %0d refills want 1", acc_rf_cnt); end
        total++; if (acc_rdata !== pat_word(32'h3000, 0) || acc_lat !== 5) begin
            bad++; $display("[TB] FAIL rmid_reread: got %h lat %0d want %h lat 5", acc_rdata, acc_lat, pat_word(32'h3000, 0));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_lru_victim();
        test_dirty_evict();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
